// File: rtl/router_pkg.sv
// Shared definitions for the router output schedulers.
//   N_PORTS_DEF  : default number of input ports competing for one output.
//   port_mask_t  : one bit per input port (request / grant vectors).
//   port_id_t    : binary input-port index.
//   sched_state_e: output-port allocation state.
package router_pkg;

    localparam int N_PORTS_DEF = 16;
    localparam int ID_W_DEF    = $clog2(N_PORTS_DEF);

    typedef logic [N_PORTS_DEF-1:0] port_mask_t;
    typedef logic [ID_W_DEF-1:0]    port_id_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } sched_state_e;

endpackage

// File: rtl/router_output_scheduler_if.sv
// Handshake bundle between the input side / crossbar and one output scheduler.
//   req         : per-input request level for this output.
//   flit_valid  : granted input presents a flit (muxed by grant).
//   flit_tail   : current flit closes its packet (qualified by flit_valid).
//   out_ready   : downstream accepts a flit this cycle.
//   grant       : one-hot crossbar select, zero when idle.
//   grant_id    : binary index of the granted input, valid while busy.
//   busy        : output port is allocated.
//   timeout_err : one-cycle pulse on a watchdog release.
// master = requesters/crossbar side, slave = the scheduler.
interface router_output_scheduler_if
    import router_pkg::*;
#(
    parameter int N_PORTS = N_PORTS_DEF,
    parameter int ID_W    = $clog2(N_PORTS)
);
    logic [N_PORTS-1:0] req;
    logic               flit_valid;
    logic               flit_tail;
    logic               out_ready;
    logic [N_PORTS-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               busy;
    logic               timeout_err;

    modport master (
        output req, flit_valid, flit_tail, out_ready,
        input  grant, grant_id, busy, timeout_err
    );

    modport slave (
        input  req, flit_valid, flit_tail, out_ready,
        output grant, grant_id, busy, timeout_err
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req           : request vector.
//   ptr           : highest-priority index for this pick.
//   found         : at least one request is set.
//   winner_id     : first set request at or above ptr, wrapping to 0.
//   winner_onehot : winner_id as a one-hot mask (zero when !found).
module rr_pick
    import router_pkg::*;
#(
    parameter int N_PORTS = N_PORTS_DEF,
    parameter int ID_W    = $clog2(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               found,
    output logic [ID_W-1:0]    winner_id,
    output logic [N_PORTS-1:0] winner_onehot
);
    logic [N_PORTS-1:0] req_hi;
    logic [N_PORTS-1:0] pick;

    assign found = |req;

    // NOTE: blocking assignments inside always_comb are intentional; the loop
    // must see its own partial results within the same evaluation.
    always_comb begin
        // NOTE: every output gets a default before any conditional code so no
        // path leaves a value unassigned (which would infer a latch).
        req_hi        = '0;
        winner_id     = '0;
        winner_onehot = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            req_hi[i] = req[i] & (ID_W'(i) >= ptr);
        end
        // Requests at/above the pointer win; otherwise wrap to the low ones.
        pick = (|req_hi) ? req_hi : req;
        // Descending scan so the lowest set index is the last one written.
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            if (pick[i]) begin
                winner_id = ID_W'(i);
            end
        end
        if (found) begin
            winner_onehot[winner_id] = 1'b1;
        end
    end
endmodule

// File: rtl/router_output_scheduler.sv
// Per-output-port packet scheduler: round-robin arbitration among N_PORTS
// inputs, grant held for a whole packet, stall watchdog for stuck inputs.
//   clk, reset_n : clock and synchronous active-low reset.
//   bus          : slave side of router_output_scheduler_if (see that file).
// Parameters: N_PORTS, ID_W, MAX_STALL (0 disables the watchdog), CNT_W.
module router_output_scheduler
    import router_pkg::*;
#(
    parameter int N_PORTS   = N_PORTS_DEF,
    parameter int ID_W      = $clog2(N_PORTS),
    parameter int MAX_STALL = 255,
    parameter int CNT_W     = 8
) (
    input logic                       clk,
    input logic                       reset_n,
    router_output_scheduler_if.slave  bus
);
    sched_state_e       state_q, state_d;
    logic [N_PORTS-1:0] grant_q, grant_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic               timeout_q, timeout_d;

    logic               found;
    logic [ID_W-1:0]    win_id;
    logic [N_PORTS-1:0] win_oh;
    logic               xfer;
    logic               rel_tail;
    logic               rel_drop;
    logic               rel_wd;

    rr_pick #(
        .N_PORTS (N_PORTS),
        .ID_W    (ID_W)
    ) u_pick (
        .req           (bus.req),
        .ptr           (rr_ptr_q),
        .found         (found),
        .winner_id     (win_id),
        .winner_onehot (win_oh)
    );

    assign xfer     = (state_q == S_BUSY) & bus.flit_valid & bus.out_ready;
    assign rel_tail = xfer & bus.flit_tail;
    assign rel_drop = ~bus.req[grant_id_q];

    generate
        if (MAX_STALL != 0) begin : g_wd
            // Fires on the MAX_STALL-th consecutive busy cycle without a transfer.
            assign rel_wd = (stall_q == CNT_W'(MAX_STALL - 1)) & ~xfer;
        end else begin : g_no_wd
            assign rel_wd = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        stall_d    = stall_q;
        timeout_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Arbitration samples req only here, so each grant is preceded
                // by at least one idle cycle.
                if (found) begin
                    state_d    = S_BUSY;
                    grant_d    = win_oh;
                    grant_id_d = win_id;
                    stall_d    = '0;
                end
            end
            S_BUSY: begin
                if (rel_tail || rel_drop || rel_wd) begin
                    state_d   = S_IDLE;
                    grant_d   = '0;
                    rr_ptr_d  = (grant_id_q == ID_W'(N_PORTS - 1)) ? '0 : grant_id_q + 1'b1;
                    stall_d   = '0;
                    // Tail and withdrawal take precedence; only a pure watchdog
                    // release is reported as an error.
                    timeout_d = ~rel_tail & ~rel_drop;
                end else if (xfer) begin
                    stall_d = '0;
                end else if (stall_q != '1) begin
                    stall_d = stall_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; reset here is synchronous, matching the rest of the router.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            stall_q    <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            stall_q    <= stall_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.busy        = (state_q == S_BUSY);
    assign bus.timeout_err = timeout_q;
endmodule

// File: tb/tb_router_output_scheduler.sv
// Directed bench for router_output_scheduler: a per-cycle vector table plus
// hand-written multi-cycle sequences. dut_a uses the default watchdog
// (255), dut_w uses MAX_STALL=8; both see the same stimulus.
module tb_router_output_scheduler;
    import router_pkg::*;

    typedef struct {
        logic       rst_n;
        port_mask_t req;
        logic       fv;
        logic       ft;
        logic       ordy;
        port_mask_t exp_grant;
        logic       exp_busy;
        logic       exp_to;
    } vec_t;

    logic       clk;
    logic       rst_n;
    port_mask_t req;
    logic       fv, ft, ordy;
    logic       mon_en;
    int         checks;
    int         failures;
    vec_t       vecs[17];

    router_output_scheduler_if #(.N_PORTS(16)) bus_a ();
    router_output_scheduler_if #(.N_PORTS(16)) bus_w ();

    assign bus_a.req        = req;
    assign bus_a.flit_valid = fv;
    assign bus_a.flit_tail  = ft;
    assign bus_a.out_ready  = ordy;
    assign bus_w.req        = req;
    assign bus_w.flit_valid = fv;
    assign bus_w.flit_tail  = ft;
    assign bus_w.out_ready  = ordy;

    router_output_scheduler #(.N_PORTS(16), .MAX_STALL(255)) dut_a (
        .clk     (clk),
        .reset_n (rst_n),
        .bus     (bus_a)
    );

    router_output_scheduler #(.N_PORTS(16), .MAX_STALL(8)) dut_w (
        .clk     (clk),
        .reset_n (rst_n),
        .bus     (bus_w)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] id_of(input port_mask_t m);
        id_of = '0;
        for (int i = 0; i < 16; i++) begin
            if (m[i]) id_of = 4'(i);
        end
    endfunction

    // Compare outputs of one DUT against expected grant/busy/timeout; grant_id
    // is only meaningful while busy.
    task automatic check_out(input bit use_w, input string tag, input port_mask_t g,
                             input logic b, input logic t);
        port_mask_t act_g;
        logic [3:0] act_id;
        logic       act_b, act_t;
        act_g  = use_w ? bus_w.grant       : bus_a.grant;
        act_id = use_w ? bus_w.grant_id    : bus_a.grant_id;
        act_b  = use_w ? bus_w.busy        : bus_a.busy;
        act_t  = use_w ? bus_w.timeout_err : bus_a.timeout_err;
        check({tag, " grant"},   32'(act_g), 32'(g));
        check({tag, " busy"},    32'(act_b), 32'(b));
        check({tag, " timeout"}, 32'(act_t), 32'(t));
        if (b) check({tag, " grant_id"}, 32'(act_id), 32'(id_of(g)));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        fv    = 1'b0;
        ft    = 1'b0;
        ordy  = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Grant must be one-hot or zero on every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (!$onehot0(bus_a.grant) || !$onehot0(bus_w.grant)) begin
                failures++;
                $display("FAIL onehot0 grant: got a=0x%0h w=0x%0h required one-hot or zero",
                         bus_a.grant, bus_w.grant);
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        mon_en   = 1'b0;

        //          rst   req       fv    ft    ordy  exp_grant busy  to
        vecs[0]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0}; // reset
        vecs[1]  = '{1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0}; // flits ignored idle
        vecs[2]  = '{1'b1, 16'h0006, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0}; // grant from ptr 0
        vecs[3]  = '{1'b1, 16'h0006, 1'b1, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0}; // body flit
        vecs[4]  = '{1'b1, 16'h0006, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0}; // tail, ptr=2
        vecs[5]  = '{1'b1, 16'h0006, 1'b0, 1'b0, 1'b0, 16'h0004, 1'b1, 1'b0}; // port 2 wins
        vecs[6]  = '{1'b1, 16'h0006, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0}; // single flit, ptr=3
        vecs[7]  = '{1'b1, 16'h0004, 1'b0, 1'b0, 1'b0, 16'h0004, 1'b1, 1'b0}; // wrap to port 2
        vecs[8]  = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0}; // withdraw, ptr=3
        vecs[9]  = '{1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0}; // wrap to port 0
        vecs[10] = '{1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0}; // tail+drop, ptr=1
        vecs[11] = '{1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0}; // port 1 wins
        vecs[12] = '{1'b1, 16'h8002, 1'b1, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0}; // others ignored
        vecs[13] = '{1'b1, 16'h8002, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0}; // tail, ptr=2
        vecs[14] = '{1'b1, 16'h8001, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b0}; // port 15 wins
        vecs[15] = '{1'b0, 16'h8001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0}; // reset mid-packet
        vecs[16] = '{1'b1, 16'h8001, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0}; // ptr back to 0

        rst_n = 1'b0;
        req   = '0;
        fv    = 1'b0;
        ft    = 1'b0;
        ordy  = 1'b0;
        tick();
        mon_en = 1'b1;

        for (int i = 0; i < 17; i++) begin
            rst_n = vecs[i].rst_n;
            req   = vecs[i].req;
            fv    = vecs[i].fv;
            ft    = vecs[i].ft;
            ordy  = vecs[i].ordy;
            tick();
            check_out(1'b0, $sformatf("vec%0d", i), vecs[i].exp_grant,
                      vecs[i].exp_busy, vecs[i].exp_to);
        end

        // Reset in the middle of a packet.
        do_reset();
        req = 16'h0004;
        tick();
        check_out(1'b0, "rst_mid grant", 16'h0004, 1'b1, 1'b0);
        rst_n = 1'b0;
        tick();
        check_out(1'b0, "rst_mid reset", 16'h0000, 1'b0, 1'b0);
        rst_n = 1'b1;
        req   = 16'h0006;
        tick();
        check_out(1'b0, "rst_mid after", 16'h0002, 1'b1, 1'b0);

        // Fairness: all ports requesting, 2-flit packets, 0..15,0.
        do_reset();
        req  = 16'hFFFF;
        fv   = 1'b1;
        ordy = 1'b1;
        for (int k = 0; k < 17; k++) begin
            port_mask_t exp_g;
            exp_g = port_mask_t'(1) << (k % 16);
            ft = 1'b0;
            tick();
            check_out(1'b0, $sformatf("rr%0d grant", k), exp_g, 1'b1, 1'b0);
            tick();
            check_out(1'b0, $sformatf("rr%0d hold", k), exp_g, 1'b1, 1'b0);
            ft = 1'b1;
            tick();
            check_out(1'b0, $sformatf("rr%0d idle", k), 16'h0000, 1'b0, 1'b0);
        end

        // Wrap-around: port 15 packet leaves ptr at 0.
        do_reset();
        req = 16'h8000;
        tick();
        check_out(1'b0, "wrap p15", 16'h8000, 1'b1, 1'b0);
        fv = 1'b1; ft = 1'b1; ordy = 1'b1;
        tick();
        check_out(1'b0, "wrap p15 end", 16'h0000, 1'b0, 1'b0);
        req = 16'h8001; fv = 1'b0; ft = 1'b0;
        tick();
        check_out(1'b0, "wrap p0", 16'h0001, 1'b1, 1'b0);
        fv = 1'b1; ft = 1'b1;
        tick();
        check_out(1'b0, "wrap p0 end", 16'h0000, 1'b0, 1'b0);
        fv = 1'b0; ft = 1'b0;
        tick();
        check_out(1'b0, "wrap p15 again", 16'h8000, 1'b1, 1'b0);

        // Backpressure: tail presented but not accepted for 10 cycles.
        do_reset();
        req = 16'h0008;
        tick();
        check_out(1'b0, "bp grant", 16'h0008, 1'b1, 1'b0);
        fv = 1'b1; ft = 1'b1; ordy = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            check_out(1'b0, $sformatf("bp hold%0d", c), 16'h0008, 1'b1, 1'b0);
        end
        ordy = 1'b1;
        tick();
        check_out(1'b0, "bp release", 16'h0000, 1'b0, 1'b0);

        // Watchdog (MAX_STALL=8) on dut_w.
        do_reset();
        req = 16'h0020;
        tick();
        check_out(1'b1, "wd grant", 16'h0020, 1'b1, 1'b0);
        for (int c = 1; c < 8; c++) begin
            tick();
            check_out(1'b1, $sformatf("wd stall%0d", c), 16'h0020, 1'b1, 1'b0);
        end
        tick();
        check_out(1'b1, "wd fire", 16'h0000, 1'b0, 1'b1);
        req = 16'h0060;
        tick();
        check_out(1'b1, "wd next", 16'h0040, 1'b1, 1'b0);

        // Request withdrawal mid-packet.
        do_reset();
        req = 16'h0080;
        tick();
        check_out(1'b0, "wdraw grant", 16'h0080, 1'b1, 1'b0);
        fv = 1'b1; ft = 1'b0; ordy = 1'b1;
        tick();
        check_out(1'b0, "wdraw body", 16'h0080, 1'b1, 1'b0);
        req = 16'h0000;
        tick();
        check_out(1'b0, "wdraw release", 16'h0000, 1'b0, 1'b0);
        req = 16'h0180; fv = 1'b0;
        tick();
        check_out(1'b0, "wdraw next", 16'h0100, 1'b1, 1'b0);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
